// File: rtl/fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_pkg : pointer-width helper and full/empty pointer compares  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package fifo_pkg;

    function automatic int ptr_width(input int asize);
        return asize + 1;
    endfunction

    // Pointers are zero-extended to 32 bits so one function serves any ASIZE.
    function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp,
                                       input int asize);
        logic [31:0] m;
        m = (32'd1 << (asize + 1)) - 32'd1;
        return ((wp ^ rp) & m) == 32'd0;
    endfunction

    function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp,
                                      input int asize);
        logic [31:0] m;
        m = (32'd1 << (asize + 1)) - 32'd1;
        return ((wp ^ rp) & m) == (32'd1 << asize);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fifo_ptr_cnt : enable-gated wrap counter with synchronous reset  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module fifo_ptr_cnt #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-2:0] addr,
    output logic [WIDTH-1:0] ptr_nxt
);

    logic [WIDTH-1:0] r_ptr;

    always_comb begin
        ptr_nxt = r_ptr + {{(WIDTH-1){1'b0}}, inc};
    end

    assign addr = r_ptr[WIDTH-2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo_ctrl : single-clock FIFO controller for fifomem        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int ASIZE    = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic             rinc,
    input  logic             clr_err,
    output logic [ASIZE-1:0] waddr,
    output logic [ASIZE-1:0] raddr,
    output logic             wclken,
    output logic             rclken,
    output logic             wfull,
    output logic             rempty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [ASIZE:0]   count,
    output logic             rvalid,
    output logic             overflow,
    output logic             underflow
);

    localparam int             PW          = ptr_width(ASIZE);
    localparam int             DEPTH       = 2 ** ASIZE;
    localparam logic [PW-1:0]  C_AF_LEVEL  = PW'(AF_LEVEL);
    localparam logic [PW-1:0]  C_AE_LEVEL  = PW'(AE_LEVEL);
    localparam logic           C_AF_RST    = (AF_LEVEL == 0);

    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af_level
        $error("sync_fifo_ctrl: AF_LEVEL out of range 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae_level
        $error("sync_fifo_ctrl: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic [PW-1:0] w_wptr_nxt;
    logic [PW-1:0] w_rptr_nxt;
    logic [PW-1:0] w_cnt_nxt;
    logic [31:0]   w_wp32;
    logic [31:0]   w_rp32;

    // Accept decisions use only registered flags, so enables never depend on themselves.
    assign w_wr_acc = winc & ~wfull  & ~rst;
    assign w_rd_acc = rinc & ~rempty & ~rst;
    assign wclken   = w_wr_acc;
    assign rclken   = w_rd_acc;

    fifo_ptr_cnt #(.WIDTH(PW)) u_wptr (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_wr_acc),
        .addr    (waddr),
        .ptr_nxt (w_wptr_nxt)
    );

    fifo_ptr_cnt #(.WIDTH(PW)) u_rptr (
        .clk     (clk),
        .rst     (rst),
        .inc     (w_rd_acc),
        .addr    (raddr),
        .ptr_nxt (w_rptr_nxt)
    );

    assign w_cnt_nxt = w_wptr_nxt - w_rptr_nxt;
    assign w_wp32    = {{(32-PW){1'b0}}, w_wptr_nxt};
    assign w_rp32    = {{(32-PW){1'b0}}, w_rptr_nxt};

    always_ff @(posedge clk) begin
        if (rst) begin
            count        <= '0;
            rempty       <= 1'b1;
            wfull        <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= C_AF_RST;
            rvalid       <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            count        <= w_cnt_nxt;
            rempty       <= ptr_empty(w_wp32, w_rp32, ASIZE);
            wfull        <= ptr_full(w_wp32, w_rp32, ASIZE);
            almost_full  <= (w_cnt_nxt >= C_AF_LEVEL);
            almost_empty <= (w_cnt_nxt <= C_AE_LEVEL);
            rvalid       <= w_rd_acc;
            // A fresh error takes priority over a simultaneous clear.
            if (winc & wfull) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (rinc & rempty) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
- Single-clock controller that sequences the dual-port `fifomem` block as a synchronous FIFO.
- Both memory clocks tie to `clk`.
- Owns the write/read pointers and drives the memory address and enable signals.
- Produces full/empty/almost flags, an occupancy count, a read-data-valid strobe and sticky overflow/underflow errors for the surrounding datapath.

Parameters:
- ASIZE, 4, address width; DEPTH = 2**ASIZE entries.
- AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (range 1..DEPTH).
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (range 0..DEPTH-1).

Ports:
- clk  in  1  single clock; drives the controller and both memory clock inputs.
- rst  in  1  synchronous, active-high reset.
- winc  in  1  write request; the data is on the memory wdata bus this cycle.
- rinc  in  1  read request.
- clr_err  in  1  clears the sticky error flags.
- waddr  out  ASIZE  memory write address.
- raddr  out  ASIZE  memory read address.
- wclken  out  1  memory write enable.
- rclken  out  1  memory read enable.
- wfull  out  1  FIFO full.
- rempty  out  1  FIFO empty.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  ASIZE+1  occupancy, 0..DEPTH.
- rvalid  out  1  memory rdata is valid this cycle.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Pointers
  - wptr and rptr are (ASIZE+1)-bit binary registers; the MSB is the wrap bit.
  - waddr = wptr[ASIZE-1:0]; raddr = rptr[ASIZE-1:0].
  - Both pointers wrap modulo 2**(ASIZE+1) with no special case.
- Accepting requests
  - A write is accepted when winc & ~wfull; then wclken = 1 and wptr increments at the next edge.
  - A read is accepted when rinc & ~rempty; then rclken = 1 and rptr increments at the next edge.
  - wclken and rclken are combinational from the request and the current registered flags.
- Flags and count
  - All flags and count are registered, computed from the next-state pointers.
  - Every flag reflects the cumulative accept history up to the previous edge. Flags never glitch.
  - count = wptr - rptr, modulo 2**(ASIZE+1).
  - rempty = (wptr == rptr).
  - wfull = (addresses equal) & (wrap bits differ).
- Read latency
  - The memory read is registered. rvalid is a register set to the read-accept signal, so it is high exactly one cycle after rclken.
  - Back-to-back reads give rvalid high on consecutive cycles.
- Simultaneous events
  - Write and read both accepted in one cycle: count is unchanged and both pointers advance.
  - When full: rinc & winc accepts only the read. The write is rejected and sets overflow; wfull deasserts next cycle.
  - When empty: winc & rinc accepts only the write. The read is rejected and sets underflow; no write-through bypass.
- Errors
  - overflow sets on winc & wfull; underflow sets on rinc & rempty.
  - Both hold until clr_err or rst.
  - If clr_err and a new error occur in the same cycle, the error wins and the flag stays 1.
- Reset (rst = 1 at an edge)
  - wptr = rptr = 0; count = 0; rempty = 1; wfull = 0.
  - almost_empty = 1; almost_full = (AF_LEVEL == 0), which is 0 for legal values.
  - rvalid = 0; overflow = underflow = 0.
  - wclken and rclken are forced to 0 during reset.
  - Memory contents are not cleared.
  - A reset mid-stream discards all entries. A read accepted in the cycle before reset still produces no rvalid after reset.
- Parameter checks
  - AF_LEVEL outside 1..DEPTH or AE_LEVEL outside 0..DEPTH-1 is an elaboration error.

Decomposition:
- Shared package fifo_pkg holds:
  - the ASIZE-derived helper function for pointer width (ASIZE+1);
  - the full/empty compare function, reused by the async FIFO variant.
- One natural sub-module: fifo_ptr_cnt.
  - An (ASIZE+1)-bit enable-gated wrap counter with synchronous reset.
  - Instantiated twice, for wptr and rptr.
- Flag, count and error logic stays in the top level.

Test Plan:
- Reset then idle -> rempty = 1, wfull = 0, count = 0, almost_empty = 1, rvalid = 0, no enables.
- Write 16 words with winc held -> count steps 1..16; almost_full rises when count reaches 14; wfull = 1 after the 16th edge. A 17th winc -> wclken = 0 and overflow = 1.
- Fill to 16, then read 16 with rinc held -> rvalid high for 16 consecutive cycles, each starting one cycle after its rclken; data in write order; rempty = 1 after the last read. Then rinc -> underflow = 1; clr_err -> 0.
- Hold count = 8 with continuous winc & rinc for 40 cycles -> count stays 8; waddr and raddr wrap past 15 to 0 at least twice; data order is preserved.
- Full plus simultaneous winc & rinc -> only the read is accepted; count = 15; overflow = 1. Empty plus both -> only the write is accepted; count = 1; underflow = 1.
- Assert rst with count = 5 and a read in flight -> next cycle count = 0, rempty = 1, rvalid = 0, errors cleared.
